// File: rtl/instr_fetch_mem_if.sv
// Fetch and word-load bus between the fetch stage / loader (master) and the
// instruction memory (slave).
interface instr_fetch_mem_if #(
    parameter int ADDR_W = 8
);
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_ready;
    logic              fetch_valid;
    logic [31:0]       fetch_instr;
    logic              fetch_fault;

    logic              load_en;
    logic [ADDR_W-1:0] load_addr;
    logic [31:0]       load_word;
    logic              load_ready;
    logic              load_err;

    modport master (
        output fetch_req, fetch_addr, load_en, load_addr, load_word,
        input  fetch_ready, fetch_valid, fetch_instr, fetch_fault, load_ready, load_err
    );

    modport slave (
        input  fetch_req, fetch_addr, load_en, load_addr, load_word,
        output fetch_ready, fetch_valid, fetch_instr, fetch_fault, load_ready, load_err
    );
endinterface

// File: rtl/instr_fetch_mem.sv
// Byte-addressed big-endian instruction memory with a latency-configurable
// registered fetch port and a word-load port. Storage is four byte-lane RAMs.
module instr_fetch_mem #(
    parameter int ADDR_W  = 8,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 1
) (
    input logic              clk,
    input logic              rst,
    instr_fetch_mem_if.slave bus
);
    localparam int WORDS = DEPTH / 4;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [ADDR_W-1:0] LAST_WORD  = ADDR_W'(DEPTH - 4);
    // Edges spent in BUSY; the word is read on the last of them.
    localparam logic [3:0]        BUSY_EDGES = 4'(LATENCY - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t            state_reg, state_next;
    logic [3:0]        cnt_reg, cnt_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic              fetch_valid_reg;
    logic              fetch_fault_reg;
    logic              load_err_reg;

    logic              fetch_accept;
    logic              load_accept;
    logic              read_fire;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_fault;
    logic [IDX_W-1:0]  rd_idx;
    logic [IDX_W-1:0]  wr_idx;

    function automatic logic bad_addr(input logic [ADDR_W-1:0] a);
        return (a[1:0] != 2'b00) || (a > LAST_WORD);
    endfunction

    always_comb begin
        state_next       = state_reg;
        cnt_next         = cnt_reg;
        addr_next        = addr_reg;
        fetch_accept     = 1'b0;
        load_accept      = 1'b0;
        read_fire        = 1'b0;
        bus.fetch_ready  = 1'b0;
        bus.load_ready   = 1'b0;
        case (state_reg)
            IDLE: begin
                bus.load_ready  = 1'b1;
                bus.fetch_ready = !bus.load_en;
                load_accept     = bus.load_en && !bad_addr(bus.load_addr);
                fetch_accept    = bus.fetch_req && !bus.load_en;
                if (fetch_accept) begin
                    // Single-cycle latency reads on the acceptance edge itself.
                    read_fire = (LATENCY == 1);
                    if (LATENCY > 1) begin
                        state_next = BUSY;
                        cnt_next   = BUSY_EDGES;
                        addr_next  = bus.fetch_addr;
                    end
                end
            end
            BUSY: begin
                cnt_next = cnt_reg - 4'd1;
                if (cnt_reg == 4'd1) begin
                    read_fire  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign rd_addr  = (state_reg == IDLE) ? bus.fetch_addr : addr_reg;
    assign rd_fault = bad_addr(rd_addr);
    assign rd_idx   = rd_addr[IDX_W+1:2];
    assign wr_idx   = bus.load_addr[IDX_W+1:2];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            cnt_reg         <= 4'd0;
            addr_reg        <= '0;
            fetch_valid_reg <= 1'b0;
            fetch_fault_reg <= 1'b0;
            load_err_reg    <= 1'b0;
        end else begin
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            addr_reg        <= addr_next;
            fetch_valid_reg <= read_fire;
            if (read_fire) begin
                fetch_fault_reg <= rd_fault;
            end
            load_err_reg    <= bus.load_en && !load_accept;
        end
    end

    // Lane gi holds byte gi of every word, so lane 0 is the most significant
    // byte. The RAM contents come up zero from configuration and survive rst.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem [WORDS];
            logic [7:0] rd_byte_reg;

            always_ff @(posedge clk) begin
                if (!rst && load_accept) begin
                    mem[wr_idx] <= bus.load_word[31-8*gi -: 8];
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    rd_byte_reg <= 8'h00;
                end else if (read_fire) begin
                    rd_byte_reg <= rd_fault ? 8'h00 : mem[rd_idx];
                end
            end
        end
    endgenerate

    assign bus.fetch_instr = {g_lane[0].rd_byte_reg, g_lane[1].rd_byte_reg,
                              g_lane[2].rd_byte_reg, g_lane[3].rd_byte_reg};
    assign bus.fetch_valid = fetch_valid_reg;
    assign bus.fetch_fault = fetch_fault_reg;
    assign bus.load_err    = load_err_reg;
endmodule

// File: tb/tb_instr_fetch_mem.sv
// Bench for instr_fetch_mem: directed table and corner sequences, then random
// traffic checked every cycle against a timestamp-based reference model.
module tb_instr_fetch_mem;
    localparam int AW    = 8;
    localparam int DEPTH = 64;
    localparam int LAT   = 3;

    logic clk = 1'b0;
    logic rst;

    instr_fetch_mem_if #(.ADDR_W(AW)) ifc ();

    instr_fetch_mem #(.ADDR_W(AW), .DEPTH(DEPTH), .LATENCY(LAT)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: byte array plus one outstanding fetch with a due cycle.
    logic [7:0]  m_mem [DEPTH];
    bit          m_pend;
    int          m_done;
    logic [31:0] m_pinstr, m_instr;
    bit          m_pfault, m_fault, m_lerr;

    bit          last_ready, last_lready, last_valid, last_fault, last_lerr;
    logic [31:0] last_instr;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] instr;
        logic        fault;
    } fvec_t;
    fvec_t tbl [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: drive inputs, compare with the model mid-cycle, then
    // advance the model across the rising edge.
    task automatic step(input bit r, input bit fr, input logic [7:0] fa,
                        input bit le, input logic [7:0] la, input logic [31:0] lw);
        bit busy, valid_e, lok;
        int ia, il;
        rst            = r;
        ifc.fetch_req  = fr;
        ifc.fetch_addr = fa;
        ifc.load_en    = le;
        ifc.load_addr  = la;
        ifc.load_word  = lw;
        @(negedge clk);
        busy    = m_pend && (cyc < m_done);
        valid_e = m_pend && (cyc == m_done);
        if (valid_e) begin
            m_instr = m_pinstr;
            m_fault = m_pfault;
        end
        last_ready  = ifc.fetch_ready;
        last_lready = ifc.load_ready;
        last_valid  = ifc.fetch_valid;
        last_instr  = ifc.fetch_instr;
        last_fault  = ifc.fetch_fault;
        last_lerr   = ifc.load_err;
        chk1("fetch_valid", ifc.fetch_valid, valid_e);
        chk1("fetch_ready", ifc.fetch_ready, !busy && !le);
        chk1("load_ready", ifc.load_ready, !busy);
        chk1("load_err", ifc.load_err, m_lerr);
        chk("fetch_instr", ifc.fetch_instr, m_instr);
        chk1("fetch_fault", ifc.fetch_fault, m_fault);
        @(posedge clk);
        cyc++;
        if (r) begin
            m_pend  = 1'b0;
            m_instr = 32'h0;
            m_fault = 1'b0;
            m_lerr  = 1'b0;
        end else begin
            m_lerr = 1'b0;
            if (le) begin
                il  = int'(la);
                lok = !busy && (il % 4 == 0) && (il <= DEPTH - 4);
                if (lok) begin
                    for (int b = 0; b < 4; b++) m_mem[il + b] = lw[31-8*b -: 8];
                end else begin
                    m_lerr = 1'b1;
                end
            end
            if (fr && !busy && !le) begin
                ia       = int'(fa);
                m_pend   = 1'b1;
                m_done   = cyc + LAT - 1;
                m_pfault = (ia % 4 != 0) || (ia > DEPTH - 4);
                m_pinstr = m_pfault ? 32'h0
                         : {m_mem[ia], m_mem[ia+1], m_mem[ia+2], m_mem[ia+3]};
            end
        end
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 32'h0);
    endtask

    task automatic do_load(input logic [7:0] a, input logic [31:0] w, input bit exp_err);
        step(1'b0, 1'b0, 8'h00, 1'b1, a, w);
        idle();
        chk1("load_err_pulse", last_lerr, exp_err);
        $display("load  addr=0x%02h word=0x%08h err=%0b", a, w, last_lerr);
    endtask

    task automatic do_fetch(input logic [7:0] a, output logic [31:0] instr,
                            output bit fault, output int lat, output int tries);
        bit acc, got;
        int t0;
        acc = 1'b0; got = 1'b0; t0 = 0;
        instr = 32'h0; fault = 1'b0; lat = -1; tries = 0;
        for (int i = 0; i < 20 && !acc; i++) begin
            step(1'b0, 1'b1, a, 1'b0, 8'h00, 32'h0);
            tries++;
            if (last_ready) begin
                acc = 1'b1;
                t0  = cyc;
            end
        end
        chk1("fetch_accepted", acc, 1'b1);
        for (int i = 0; i < 20 && acc && !got; i++) begin
            idle();
            if (last_valid) begin
                got   = 1'b1;
                lat   = cyc - t0;
                instr = last_instr;
                fault = last_fault;
            end
        end
        chk1("fetch_completed", got, 1'b1);
        $display("fetch addr=0x%02h instr=0x%08h fault=%0b latency=%0d", a, instr, fault, lat);
    endtask

    function automatic logic [7:0] pick_addr();
        if ($urandom_range(0, 3) != 0) return 8'($urandom_range(0, DEPTH/4 - 1) * 4);
        return 8'($urandom_range(0, 255));
    endfunction

    initial begin
        logic [31:0] instr;
        logic [31:0] vins [2];
        bit          fault, acc, acc2, seen;
        int          lat, tries, t0, n, lowcnt;
        int          vlat [2];

        for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'h00;
        m_pend = 1'b0; m_done = 0; m_pinstr = 32'h0; m_instr = 32'h0;
        m_pfault = 1'b0; m_fault = 1'b0; m_lerr = 1'b0;
        vins[0] = 32'h0; vins[1] = 32'h0; vlat[0] = 0; vlat[1] = 0;

        tbl[0] = '{8'h00, 32'h00430820, 1'b0};
        tbl[1] = '{8'h02, 32'h00000000, 1'b1};
        tbl[2] = '{8'h3C, 32'h11223344, 1'b0};
        tbl[3] = '{8'h40, 32'h00000000, 1'b1};
        tbl[4] = '{8'h24, 32'h00000000, 1'b0};
        tbl[5] = '{8'h20, 32'hCAFEF00D, 1'b0};
        tbl[6] = '{8'hFF, 32'h00000000, 1'b1};
        tbl[7] = '{8'h3D, 32'h00000000, 1'b1};

        rst = 1'b1;
        ifc.fetch_req = 1'b0; ifc.fetch_addr = '0;
        ifc.load_en = 1'b0; ifc.load_addr = '0; ifc.load_word = '0;
        repeat (2) @(posedge clk);
        #1;

        // Reset values
        step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 32'h0);
        chk1("rst_fetch_valid", last_valid, 1'b0);
        chk("rst_fetch_instr", last_instr, 32'h0);
        chk1("rst_fetch_fault", last_fault, 1'b0);
        chk1("rst_load_err", last_lerr, 1'b0);
        chk1("rst_fetch_ready", last_ready, 1'b1);
        chk1("rst_load_ready", last_lready, 1'b1);

        // Reset together with load_en: no write, no error
        step(1'b1, 1'b0, 8'h00, 1'b1, 8'h00, 32'hFFFFFFFF);
        idle();
        chk1("rst_load_no_err", last_lerr, 1'b0);
        do_fetch(8'h00, instr, fault, lat, tries);
        chk("rst_load_no_write", instr, 32'h0);

        do_load(8'h00, 32'h00430820, 1'b0);
        do_load(8'h3C, 32'h11223344, 1'b0);
        do_load(8'h20, 32'hCAFEF00D, 1'b0);
        do_load(8'h04, 32'hAAAA0004, 1'b0);
        do_load(8'h08, 32'hBBBB0008, 1'b0);

        for (int i = 0; i < 8; i++) begin
            do_fetch(tbl[i].addr, instr, fault, lat, tries);
            chk("tbl_instr", instr, tbl[i].instr);
            chk1("tbl_fault", fault, tbl[i].fault);
            chk("tbl_latency", lat, LAT);
        end

        // Back-to-back: fetch_req held for 0x04, then for 0x08
        acc = 1'b0; t0 = 0;
        for (int i = 0; i < 20 && !acc; i++) begin
            step(1'b0, 1'b1, 8'h04, 1'b0, 8'h00, 32'h0);
            if (last_ready) begin
                acc = 1'b1;
                t0  = cyc;
            end
        end
        chk1("b2b_accept", acc, 1'b1);
        acc2 = 1'b0; n = 0; lowcnt = 0;
        for (int i = 0; i < 16 && n < 2; i++) begin
            step(1'b0, !acc2, 8'h08, 1'b0, 8'h00, 32'h0);
            if (last_ready && !acc2) acc2 = 1'b1;
            if (!last_ready) lowcnt++;
            if (last_valid) begin
                vlat[n] = cyc - t0;
                vins[n] = last_instr;
                n++;
            end
        end
        chk("b2b_pulses", n, 2);
        chk("b2b_lat_first", vlat[0], LAT);
        chk("b2b_lat_second", vlat[1], 2 * LAT);
        chk("b2b_instr_first", vins[0], 32'hAAAA0004);
        chk("b2b_instr_second", vins[1], 32'hBBBB0008);
        chk("b2b_ready_low", lowcnt, 2 * (LAT - 1));
        $display("b2b   lat=%0d,%0d instr=0x%08h,0x%08h ready_low=%0d", vlat[0], vlat[1], vins[0], vins[1], lowcnt);

        // Load wins over a simultaneous fetch
        step(1'b0, 1'b1, 8'h10, 1'b1, 8'h10, 32'hDEADBEEF);
        chk1("prio_ready_low", last_ready, 1'b0);
        do_fetch(8'h10, instr, fault, lat, tries);
        chk("prio_instr", instr, 32'hDEADBEEF);
        chk("prio_tries", tries, 1);

        // Rejected loads leave memory unchanged
        do_load(8'h01, 32'h12345678, 1'b1);
        do_load(8'h40, 32'h12345678, 1'b1);
        do_fetch(8'h00, instr, fault, lat, tries);
        chk("reject_mem_kept", instr, 32'h00430820);

        // Load while BUSY
        acc = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) begin
            step(1'b0, 1'b1, 8'h20, 1'b0, 8'h00, 32'h0);
            acc = last_ready;
        end
        step(1'b0, 1'b0, 8'h00, 1'b1, 8'h20, 32'h55555555);
        chk1("busy_load_ready", last_lready, 1'b0);
        idle();
        chk1("busy_load_err", last_lerr, 1'b1);
        $display("load  addr=0x20 word=0x55555555 err=%0b (busy)", last_lerr);
        do_fetch(8'h20, instr, fault, lat, tries);
        chk("busy_load_mem_kept", instr, 32'hCAFEF00D);

        // Reset two cycles after acceptance aborts the fetch
        acc = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) begin
            step(1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 32'h0);
            acc = last_ready;
        end
        idle();
        step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 32'h0);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            idle();
            if (last_valid) seen = 1'b1;
        end
        chk1("rst_abort_no_valid", seen, 1'b0);
        chk("rst_abort_instr", last_instr, 32'h0);
        chk1("rst_abort_ready", last_ready, 1'b1);
        do_fetch(8'h00, instr, fault, lat, tries);
        chk("rst_mem_retained", instr, 32'h00430820);

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 49) == 0, 1'($urandom_range(0, 1)), pick_addr(),
                 $urandom_range(0, 3) == 0, pick_addr(), $urandom);
        end
        repeat (LAT + 2) idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
